alu_arb: RTL and testbench
==========================

ALU_ARB -- requirements
Module: alu_arb

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand/result width.
REQ-002 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have ports req_valid_0 / req_valid_1  input  1  requester 0/1 operation valid.
REQ-005 SHALL have ports req_ready_0 / req_ready_1  output  1  requester 0/1 operation accepted this cycle.
REQ-006 SHALL have ports req_a_0, req_b_0, req_a_1, req_b_1  input  WIDTH  operands per requester.
REQ-007 SHALL have ports req_ctrl_0 / req_ctrl_1  input  4  ALU op code per requester, team ALU encoding 0000..1001.
REQ-008 SHALL have ports rsp_valid_0 / rsp_valid_1  output  1  result valid for requester 0/1.
REQ-009 SHALL have ports rsp_ready_0 / rsp_ready_1  input  1  requester 0/1 consumes result.
REQ-010 SHALL have port rsp_data  output  WIDTH  registered result, meaningful only while some rsp_valid_x=1.
REQ-011 SHALL have port rsp_zero  output  1  registered zero flag of rsp_data.

Function
REQ-012 SHALL implement FSM states IDLE and RESP; one operation outstanding at most.
REQ-013 IDLE: if any req_valid_x, SHALL grant one requester, assert its req_ready_x combinationally, capture ALU result/zero into rsp_data/rsp_zero, latch owner, go RESP.
REQ-014 Latency: request accepted at edge N SHALL yield rsp_valid_owner=1 after edge N, i.e. one cycle.
REQ-015 RESP: rsp_valid_owner SHALL stay 1 with rsp_data/rsp_zero stable until rsp_ready_owner=1; the other rsp_valid SHALL be 0.
REQ-016 RESP with rsp_ready_owner=1: if a request is pending, SHALL accept it same cycle (back-to-back, one result/cycle) and stay RESP; else return IDLE.
REQ-017 req_ready_x SHALL be 0 in RESP unless rsp_ready_owner=1 and x is granted; at most one req_ready high per cycle.
REQ-018 Arbitration SHALL be round-robin: both valid -> grant the requester not granted last; single valid -> grant it.
REQ-019 Last-grant pointer SHALL update only on an accepted request; reset value points to requester 1, so requester 0 wins first tie.
REQ-020 Computation SHALL use the team ALU semantics (AND, OR, ADD, SUB, XOR, SLL, SRL, SRA, SLT, SLTU; shifts by b[4:0]; add/sub wrap modulo 2^WIDTH).
REQ-021 A requester SHALL NOT be starved: with both continuously valid, grants strictly alternate.
REQ-022 Requester holding req_valid without ready SHALL see no side effect; operands sampled only on accept.

Reset
REQ-023 rst_n low SHALL force IDLE, rsp_valid_0/1=0, rsp_data=0, rsp_zero=0, last-grant=1, immediately and regardless of clk.
REQ-024 Reset mid-RESP SHALL discard the pending result; no rsp handshake for it after release.
REQ-025 req_ready_0/1 SHALL be 0 while rst_n low.

Configuration
REQ-026 Macro ALU_ARB_ILLEGAL_EN: defined -> req_ctrl in 1010..1111 SHALL produce rsp_data=0 and rsp_zero=1 (deterministic); undefined -> result for those codes unspecified (X permitted), all else identical.

Structure
REQ-027 Shared package alu_pkg SHALL hold the 4-bit op-code constants and the FSM state typedef; WIDTH stays a module parameter.
REQ-028 Round-robin grant logic SHALL be one sub-module alu_rr_arb (2 requests, last pointer in, 2 one-hot grants out); ALU datapath is the existing team ALU instantiated once.

Verification
REQ-029 Req0 ADD a=5 b=7 alone -> req_ready_0=1 same cycle, next cycle rsp_valid_0=1, rsp_data=12, rsp_zero=0.
REQ-030 Both valid after reset: req0 SUB 9-9, req1 OR 3|4, rsp_ready tied 1 -> grant order 0,1; results 0 (zero=1) then 7.
REQ-031 Req0 SRA a=0x80000000 b=4, rsp_ready_0 held 0 for 3 cycles -> rsp_data=0xF8000000 stable 3 cycles, req_ready_1=0 throughout.
REQ-032 Both requesters continuously valid 10 cycles, rsp_ready=1 -> 10 results, grants alternate 0,1,0,1..., no idle cycle.
REQ-033 rst_n low while in RESP with SLTU 1<2 pending -> rsp_valid_0 drops without clk, no response after release.
REQ-034 With ALU_ARB_ILLEGAL_EN, req1 ctrl=1111 -> rsp_data=0, rsp_zero=1; without, only handshake timing checked.

Source files
------------

// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
// Module   : alu_pkg
// Purpose  : Shared ALU op-code constants and arbiter FSM state type.
// Revision : 1.0 - initial release
// ============================================================================
package alu_pkg;

    // Team ALU op-code encoding (4-bit)
    localparam logic [3:0] OP_AND  = 4'b0000;
    localparam logic [3:0] OP_OR   = 4'b0001;
    localparam logic [3:0] OP_ADD  = 4'b0010;
    localparam logic [3:0] OP_SUB  = 4'b0011;
    localparam logic [3:0] OP_XOR  = 4'b0100;
    localparam logic [3:0] OP_SLL  = 4'b0101;
    localparam logic [3:0] OP_SRL  = 4'b0110;
    localparam logic [3:0] OP_SRA  = 4'b0111;
    localparam logic [3:0] OP_SLT  = 4'b1000;
    localparam logic [3:0] OP_SLTU = 4'b1001;

    // Arbiter FSM: idle, or holding exactly one result for its owner
    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RESP = 1'b1
    } state_t;

endpackage : alu_pkg
`default_nettype wire

// File: rtl/alu.sv
`default_nettype none
// ============================================================================
// Module   : alu
// Purpose  : Team combinational ALU (AND/OR/ADD/SUB/XOR/SLL/SRL/SRA/SLT/SLTU).
//            Config macro ALU_ARB_ILLEGAL_EN: when defined, op codes 1010..1111
//            give result 0 (zero flag 1); otherwise those results are X.
// Revision : 1.0 - initial release
// ============================================================================
module alu
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       ctrl,
    output logic [WIDTH-1:0] result,
    output logic             zero
);

    logic [4:0] w_shamt;
    assign w_shamt = b[4:0];

    // Op-code decode; add/sub wrap naturally at WIDTH bits
    always_comb begin
        result = '0;
        case (ctrl)
            OP_AND:  result = a & b;
            OP_OR:   result = a | b;
            OP_ADD:  result = a + b;
            OP_SUB:  result = a - b;
            OP_XOR:  result = a ^ b;
            OP_SLL:  result = a << w_shamt;
            OP_SRL:  result = a >> w_shamt;
            OP_SRA:  result = $unsigned($signed(a) >>> w_shamt);
            OP_SLT:  result = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
            OP_SLTU: result = {{(WIDTH-1){1'b0}}, (a < b)};
`ifdef ALU_ARB_ILLEGAL_EN
            default: result = '0;
`else
            default: result = 'x;
`endif
        endcase
    end

    assign zero = (result == '0);

endmodule : alu
`default_nettype wire

// File: rtl/alu_rr_arb.sv
`default_nettype none
// ============================================================================
// Module   : alu_rr_arb
// Purpose  : Two-requester round-robin grant. On a tie the requester that was
//            not granted last wins; a lone request is always granted.
// Revision : 1.0 - initial release
// ============================================================================
module alu_rr_arb (
    input  logic [1:0] req,
    input  logic       last,
    output logic [1:0] grant
);

    // One-hot grant; 'last' is the index of the previously accepted requester
    always_comb begin
        grant = 2'b00;
        case (req)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = last ? 2'b01 : 2'b10;
            default: grant = 2'b00;
        endcase
    end

endmodule : alu_rr_arb
`default_nettype wire

// File: rtl/alu_arb.sv
`default_nettype none
// ============================================================================
// Module   : alu_arb
// Purpose  : Shares one ALU between two requesters with round-robin
//            arbitration, one outstanding result, back-to-back throughput.
//            Config macro ALU_ARB_ILLEGAL_EN: deterministic zero result for
//            op codes 1010..1111 (see alu).
// Revision : 1.0 - initial release
// ============================================================================
module alu_arb
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid_0,
    input  logic             req_valid_1,
    output logic             req_ready_0,
    output logic             req_ready_1,
    input  logic [WIDTH-1:0] req_a_0,
    input  logic [WIDTH-1:0] req_b_0,
    input  logic [WIDTH-1:0] req_a_1,
    input  logic [WIDTH-1:0] req_b_1,
    input  logic [3:0]       req_ctrl_0,
    input  logic [3:0]       req_ctrl_1,
    output logic             rsp_valid_0,
    output logic             rsp_valid_1,
    input  logic             rsp_ready_0,
    input  logic             rsp_ready_1,
    output logic [WIDTH-1:0] rsp_data,
    output logic             rsp_zero
);

    state_t           r_state;
    logic             r_owner;
    logic             r_last;
    logic             r_valid_0;
    logic             r_valid_1;
    logic [WIDTH-1:0] r_data;
    logic             r_zero;

    logic [1:0]       w_grant;
    logic             w_owner_ready;
    logic             w_can_accept;
    logic             w_accept;
    logic             w_sel;
    logic [WIDTH-1:0] w_a;
    logic [WIDTH-1:0] w_b;
    logic [3:0]       w_ctrl;
    logic [WIDTH-1:0] w_result;
    logic             w_zero;

    alu_rr_arb u_rr_arb (
        .req   ({req_valid_1, req_valid_0}),
        .last  (r_last),
        .grant (w_grant)
    );

    // The held result is released when its owner consumes it; that same
    // cycle is free to accept a new request. Reset blocks all acceptance.
    assign w_owner_ready = (r_state == ST_RESP) && (r_owner ? rsp_ready_1 : rsp_ready_0);
    assign w_can_accept  = rst_n && ((r_state == ST_IDLE) || w_owner_ready);
    assign req_ready_0   = w_grant[0] & w_can_accept;
    assign req_ready_1   = w_grant[1] & w_can_accept;
    assign w_accept      = req_ready_0 | req_ready_1;
    assign w_sel         = w_grant[1];

    assign w_a    = w_sel ? req_a_1    : req_a_0;
    assign w_b    = w_sel ? req_b_1    : req_b_0;
    assign w_ctrl = w_sel ? req_ctrl_1 : req_ctrl_0;

    alu #(
        .WIDTH (WIDTH)
    ) u_alu (
        .a      (w_a),
        .b      (w_b),
        .ctrl   (w_ctrl),
        .result (w_result),
        .zero   (w_zero)
    );

    // FSM: capture result on accept, hold until owner consumes it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_owner   <= 1'b0;
            r_last    <= 1'b1;
            r_valid_0 <= 1'b0;
            r_valid_1 <= 1'b0;
            r_data    <= '0;
            r_zero    <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_data    <= w_result;
                        r_zero    <= w_zero;
                        r_owner   <= w_sel;
                        r_last    <= w_sel;
                        r_valid_0 <= ~w_sel;
                        r_valid_1 <= w_sel;
                        r_state   <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    if (w_accept) begin
                        r_data    <= w_result;
                        r_zero    <= w_zero;
                        r_owner   <= w_sel;
                        r_last    <= w_sel;
                        r_valid_0 <= ~w_sel;
                        r_valid_1 <= w_sel;
                        r_state   <= ST_RESP;
                    end else if (w_owner_ready) begin
                        r_valid_0 <= 1'b0;
                        r_valid_1 <= 1'b0;
                        r_state   <= ST_IDLE;
                    end
                end
                default: begin
                    r_valid_0 <= 1'b0;
                    r_valid_1 <= 1'b0;
                    r_state   <= ST_IDLE;
                end
            endcase
        end
    end

    assign rsp_valid_0 = r_valid_0;
    assign rsp_valid_1 = r_valid_1;
    assign rsp_data    = r_data;
    assign rsp_zero    = r_zero;

endmodule : alu_arb
`default_nettype wire

// File: tb/tb_alu_arb.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_arb
// Purpose  : Directed self-checking bench for alu_arb (WIDTH = 32).
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_arb;
    import alu_pkg::*;

    localparam int WIDTH = 32;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             req_valid_0 = 1'b0, req_valid_1 = 1'b0;
    logic             req_ready_0, req_ready_1;
    logic [WIDTH-1:0] req_a_0 = '0, req_b_0 = '0, req_a_1 = '0, req_b_1 = '0;
    logic [3:0]       req_ctrl_0 = '0, req_ctrl_1 = '0;
    logic             rsp_valid_0, rsp_valid_1;
    logic             rsp_ready_0 = 1'b0, rsp_ready_1 = 1'b0;
    logic [WIDTH-1:0] rsp_data;
    logic             rsp_zero;

    int vectors = 0;
    int miscompares = 0;

    alu_arb #(.WIDTH(WIDTH)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_valid_0 (req_valid_0),
        .req_valid_1 (req_valid_1),
        .req_ready_0 (req_ready_0),
        .req_ready_1 (req_ready_1),
        .req_a_0     (req_a_0),
        .req_b_0     (req_b_0),
        .req_a_1     (req_a_1),
        .req_b_1     (req_b_1),
        .req_ctrl_0  (req_ctrl_0),
        .req_ctrl_1  (req_ctrl_1),
        .rsp_valid_0 (rsp_valid_0),
        .rsp_valid_1 (rsp_valid_1),
        .rsp_ready_0 (rsp_ready_0),
        .rsp_ready_1 (rsp_ready_1),
        .rsp_data    (rsp_data),
        .rsp_zero    (rsp_zero)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Advance to just after the next rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // ---- Reset state, ready gated during reset ----
        req_valid_0 = 1'b1;
        req_ctrl_0  = OP_ADD;
        #12;
        check("rst_rdy0", {31'd0, req_ready_0}, 32'd0);
        check("rst_vld0", {31'd0, rsp_valid_0}, 32'd0);
        check("rst_vld1", {31'd0, rsp_valid_1}, 32'd0);
        check("rst_data", rsp_data, 32'd0);
        check("rst_zero", {31'd0, rsp_zero}, 32'd0);
        req_valid_0 = 1'b0;
        tick();
        rst_n = 1'b1;

        // ---- Single ADD 5+7 from requester 0 ----
        req_valid_0 = 1'b1; req_ctrl_0 = OP_ADD; req_a_0 = 32'd5; req_b_0 = 32'd7;
        #1;
        check("add_rdy0", {31'd0, req_ready_0}, 32'd1);
        check("add_rdy1", {31'd0, req_ready_1}, 32'd0);
        tick();
        req_valid_0 = 1'b0;
        check("add_vld0", {31'd0, rsp_valid_0}, 32'd1);
        check("add_vld1", {31'd0, rsp_valid_1}, 32'd0);
        check("add_data", rsp_data, 32'd12);
        check("add_zero", {31'd0, rsp_zero}, 32'd0);
        rsp_ready_0 = 1'b1;
        tick();
        check("add_done", {31'd0, rsp_valid_0}, 32'd0);
        rsp_ready_0 = 1'b0;

        // ---- Tie after reset: req0 SUB 9-9, req1 OR 3|4 ----
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        rsp_ready_0 = 1'b1; rsp_ready_1 = 1'b1;
        req_valid_0 = 1'b1; req_ctrl_0 = OP_SUB; req_a_0 = 32'd9; req_b_0 = 32'd9;
        req_valid_1 = 1'b1; req_ctrl_1 = OP_OR;  req_a_1 = 32'd3; req_b_1 = 32'd4;
        #1;
        check("tie_rdy0", {31'd0, req_ready_0}, 32'd1);
        check("tie_rdy1", {31'd0, req_ready_1}, 32'd0);
        tick();
        req_valid_0 = 1'b0;
        #1;
        check("tie_b2b_rdy1", {31'd0, req_ready_1}, 32'd1);
        check("tie_vld0", {31'd0, rsp_valid_0}, 32'd1);
        check("tie_data0", rsp_data, 32'd0);
        check("tie_zero0", {31'd0, rsp_zero}, 32'd1);
        tick();
        req_valid_1 = 1'b0;
        check("tie_vld1", {31'd0, rsp_valid_1}, 32'd1);
        check("tie_vld0_off", {31'd0, rsp_valid_0}, 32'd0);
        check("tie_data1", rsp_data, 32'd7);
        check("tie_zero1", {31'd0, rsp_zero}, 32'd0);
        tick();
        check("tie_idle", {31'd0, rsp_valid_1}, 32'd0);

        // ---- SRA hold with backpressure; req1 must wait ----
        rsp_ready_0 = 1'b0; rsp_ready_1 = 1'b0;
        req_valid_0 = 1'b1; req_ctrl_0 = OP_SRA; req_a_0 = 32'h8000_0000; req_b_0 = 32'd4;
        req_valid_1 = 1'b1; req_ctrl_1 = OP_AND; req_a_1 = 32'h0000_00F0; req_b_1 = 32'h0000_003C;
        #1;
        check("sra_rdy0", {31'd0, req_ready_0}, 32'd1);
        check("sra_rdy1", {31'd0, req_ready_1}, 32'd0);
        tick();
        req_valid_0 = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check("sra_hold_vld0", {31'd0, rsp_valid_0}, 32'd1);
            check("sra_hold_data", rsp_data, 32'hF800_0000);
            check("sra_hold_rdy1", {31'd0, req_ready_1}, 32'd0);
            tick();
        end
        rsp_ready_0 = 1'b1;
        #1;
        check("sra_rel_rdy1", {31'd0, req_ready_1}, 32'd1);
        tick();
        req_valid_1 = 1'b0;
        check("and_vld1", {31'd0, rsp_valid_1}, 32'd1);
        check("and_data", rsp_data, 32'h0000_0030);
        rsp_ready_1 = 1'b1;
        tick();
        check("and_idle", {31'd0, rsp_valid_1}, 32'd0);

        // ---- Continuous contention: strict alternation starting at 0 ----
        req_valid_0 = 1'b1; req_ctrl_0 = OP_ADD; req_b_0 = 32'd100;
        req_valid_1 = 1'b1; req_ctrl_1 = OP_SUB; req_a_1 = 32'd1000;
        for (int k = 0; k < 10; k++) begin
            req_a_0 = k;
            req_b_1 = k;
            #1;
            check("rr_rdy0", {31'd0, req_ready_0}, (k % 2 == 0) ? 32'd1 : 32'd0);
            check("rr_rdy1", {31'd0, req_ready_1}, (k % 2 == 1) ? 32'd1 : 32'd0);
            tick();
            if (k % 2 == 0) begin
                check("rr_vld0", {31'd0, rsp_valid_0}, 32'd1);
                check("rr_data0", rsp_data, 32'(k + 100));
            end else begin
                check("rr_vld1", {31'd0, rsp_valid_1}, 32'd1);
                check("rr_data1", rsp_data, 32'(1000 - k));
            end
        end
        req_valid_0 = 1'b0; req_valid_1 = 1'b0;
        tick();
        check("rr_idle0", {31'd0, rsp_valid_0}, 32'd0);
        check("rr_idle1", {31'd0, rsp_valid_1}, 32'd0);

        // ---- Asynchronous reset while a SLTU result is pending ----
        rsp_ready_0 = 1'b0;
        req_valid_0 = 1'b1; req_ctrl_0 = OP_SLTU; req_a_0 = 32'd1; req_b_0 = 32'd2;
        tick();
        req_valid_0 = 1'b0;
        check("sltu_vld0", {31'd0, rsp_valid_0}, 32'd1);
        check("sltu_data", rsp_data, 32'd1);
        #1;
        rst_n = 1'b0;
        #1;
        check("arst_vld0", {31'd0, rsp_valid_0}, 32'd0);
        check("arst_data", rsp_data, 32'd0);
        #2;
        rst_n = 1'b1;
        rsp_ready_0 = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("arst_no_rsp0", {31'd0, rsp_valid_0}, 32'd0);
            check("arst_no_rsp1", {31'd0, rsp_valid_1}, 32'd0);
        end

        // ---- Illegal op code from requester 1 ----
        rsp_ready_1 = 1'b0;
        req_valid_1 = 1'b1; req_ctrl_1 = 4'b1111; req_a_1 = 32'd5; req_b_1 = 32'd3;
        #1;
        check("ill_rdy1", {31'd0, req_ready_1}, 32'd1);
        tick();
        req_valid_1 = 1'b0;
        check("ill_vld1", {31'd0, rsp_valid_1}, 32'd1);
        check("ill_vld0", {31'd0, rsp_valid_0}, 32'd0);
`ifdef ALU_ARB_ILLEGAL_EN
        check("ill_data", rsp_data, 32'd0);
        check("ill_zero", {31'd0, rsp_zero}, 32'd1);
`endif
        rsp_ready_1 = 1'b1;
        tick();
        check("ill_done", {31'd0, rsp_valid_1}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule : tb_alu_arb
`default_nettype wire
